// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants for the binary-to-BCD conversion and display path.
package bin_to_bcd_seq_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned ADD3_THRESH = 5;
  localparam int unsigned ADD3_ADDEND = 3;
  localparam int unsigned DEF_WIDTH   = 9;
  localparam int unsigned DEF_DIGITS  = 3;

  // 10^n, used to check that DIGITS can hold the largest WIDTH-bit value.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);

  // Correct the digit before it is doubled by the following shift.
  always_comb begin
    d_o = d_i;
    if (d_i >= BCD_DIGIT_W'(ADD3_THRESH)) d_o = d_i + BCD_DIGIT_W'(ADD3_ADDEND);
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                          Clk,
  input  logic                          R,
  input  logic                          Start,
  input  logic [WIDTH-1:0]              Bin,
  output logic                          Busy,
  output logic                          Done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] BCD
);

  localparam int unsigned BW = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  if (pow10(DIGITS) < (64'd1 << WIDTH)) begin : g_illegal_digits
    $error("bin_to_bcd_seq: DIGITS too small to represent 2^WIDTH-1");
  end

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BW-1:0]     work_q, work_d;
  logic [CW-1:0]     count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [BW-1:0]     work_corr;
  logic [BW+WIDTH-1:0] cat_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i(work_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_o(work_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Next-state, datapath and registered handshake outputs.
  // Busy is registered from the current state, so it rises one cycle after
  // Start is accepted and is already low in the Done cycle.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    work_d    = work_q;
    count_d   = count_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    cat_shift = {work_corr, shift_q} << 1;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = CONV;
          shift_d = Bin;
          work_d  = '0;
          count_d = '0;
        end
      end
      CONV: begin
        work_d  = cat_shift[BW+WIDTH-1:WIDTH];
        shift_d = cat_shift[WIDTH-1:0];
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          bcd_d   = cat_shift[BW+WIDTH-1:WIDTH];
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (R) begin
      state_q <= IDLE;
      shift_q <= '0;
      work_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign BCD  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;

  logic        Clk;
  logic        R;
  logic        Start;
  logic [8:0]  Bin;
  logic        Busy;
  logic        Done;
  logic [11:0] BCD;

  int checks = 0;
  int errors = 0;
  logic [11:0] last_bcd;

  bin_to_bcd_seq #(.WIDTH(9), .DIGITS(3)) dut (
    .Clk(Clk), .R(R), .Start(Start), .Bin(Bin),
    .Busy(Busy), .Done(Done), .BCD(BCD)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: decimal digits by plain division.
  function automatic logic [11:0] dec_model(input int unsigned v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Drives one conversion from IDLE and gathers observations. Called #1 after
  // an edge. done_at is the edge index (relative to the accepting edge) of the
  // first Done, or -1 if none within the budget.
  task automatic do_conv(input logic [8:0] v, input logic [11:0] hold,
                         output int done_at, output int busy_cycles,
                         output logic [11:0] bcd_out, output int unstable);
    done_at = -1; busy_cycles = 0; unstable = 0; bcd_out = 'x;
    Start = 1'b1; Bin = v;
    @(posedge Clk); #1;
    Start = 1'b0; Bin = 9'($urandom);
    if (Busy) busy_cycles++;
    if (BCD !== hold) unstable++;
    for (int i = 1; i <= 20; i++) begin
      @(posedge Clk); #1;
      if (Busy) busy_cycles++;
      if (Done) begin
        done_at = i;
        bcd_out = BCD;
        break;
      end
      if (BCD !== hold) unstable++;
    end
  endtask

  task automatic test_reset;
    R = 1'b1; Start = 1'b1; Bin = 9'd77;
    repeat (3) @(posedge Clk);
    #1;
    Start = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", Done); end
    checks++; if (BCD !== 12'h000) begin errors++; $display("FAIL reset_bcd got=%h exp=000", BCD); end
    R = 1'b0;
    @(posedge Clk); #1;
    last_bcd = 12'h000;
  endtask

  task automatic test_directed;
    logic [8:0] vals [4];
    int d, b, u;
    logic [11:0] got;
    vals = '{9'd0, 9'd510, 9'd255, 9'd99};
    foreach (vals[n]) begin
      do_conv(vals[n], last_bcd, d, b, got, u);
      checks++; if (d !== 9) begin errors++; $display("FAIL dir_latency v=%0d got=%0d exp=9", vals[n], d); end
      checks++; if (b !== 8) begin errors++; $display("FAIL dir_busy_cycles v=%0d got=%0d exp=8", vals[n], b); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL dir_busy_in_done v=%0d got=%b exp=0", vals[n], Busy); end
      checks++; if (got !== dec_model(vals[n])) begin errors++; $display("FAIL dir_bcd v=%0d got=%h exp=%h", vals[n], got, dec_model(vals[n])); end
      checks++; if (u !== 0) begin errors++; $display("FAIL dir_hold v=%0d got=%0d unstable cycles exp=0", vals[n], u); end
      last_bcd = dec_model(vals[n]);
      @(posedge Clk); #1;
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL dir_done_width v=%0d got=%b exp=0", vals[n], Done); end
    end
  endtask

  task automatic test_ignore_start;
    int dones = 0, first = -1;
    logic [11:0] got = 'x;
    Start = 1'b1; Bin = 9'd123;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge Clk); #1;
      if (i == 4) begin Start = 1'b1; Bin = 9'd7; end
      if (i == 5) Start = 1'b0;
      if (Done) begin
        dones++;
        if (first < 0) begin first = i; got = BCD; end
      end
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ign_done_count got=%0d exp=1", dones); end
    checks++; if (first !== 9) begin errors++; $display("FAIL ign_latency got=%0d exp=9", first); end
    checks++; if (got !== 12'h123) begin errors++; $display("FAIL ign_bcd got=%h exp=123", got); end
    last_bcd = 12'h123;
  endtask

  task automatic test_reset_abort;
    int dones = 0;
    Start = 1'b1; Bin = 9'd300;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    R = 1'b1;
    @(posedge Clk); #1;
    R = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", Busy); end
    checks++; if (BCD !== 12'h000) begin errors++; $display("FAIL abort_bcd got=%h exp=000", BCD); end
    if (Done) dones++;
    for (int i = 0; i < 15; i++) begin
      @(posedge Clk); #1;
      if (Done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    last_bcd = 12'h000;
  endtask

  task automatic test_back_to_back;
    int t1 = -1, t2 = -1, n = 0;
    logic [11:0] b1 = 'x, b2 = 'x;
    Start = 1'b1; Bin = 9'd42;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (Done) begin
        n++;
        if (n == 1) begin t1 = i; b1 = BCD; Bin = 9'd407; end
        else begin t2 = i; b2 = BCD; Start = 1'b0; break; end
      end
    end
    Start = 1'b0;
    checks++; if (b1 !== 12'h042) begin errors++; $display("FAIL b2b_first got=%h exp=042", b1); end
    checks++; if (b2 !== 12'h407) begin errors++; $display("FAIL b2b_second got=%h exp=407", b2); end
    checks++; if ((t2 - t1) !== 10 || t1 < 0) begin errors++; $display("FAIL b2b_spacing got=%0d exp=10", t2 - t1); end
    last_bcd = 12'h407;
  endtask

  task automatic test_sweep;
    int d, b, u;
    logic [11:0] got;
    int bad_val = 0, bad_dig = 0, bad_lat = 0, bad_hold = 0;
    for (int v = 0; v < 512; v++) begin
      do_conv(9'(v), last_bcd, d, b, got, u);
      checks++;
      if (got !== dec_model(v)) begin
        errors++; bad_val++;
        if (bad_val < 5) $display("FAIL sweep_bcd v=%0d got=%h exp=%h", v, got, dec_model(v));
      end
      checks++;
      if (got[3:0] > 4'd9 || got[7:4] > 4'd9 || got[11:8] > 4'd9) begin
        errors++; bad_dig++;
        if (bad_dig < 5) $display("FAIL sweep_digit_range v=%0d got=%h exp=digits<=9", v, got);
      end
      checks++;
      if (d !== 9 || u !== 0) begin
        errors++; bad_lat++;
        if (bad_lat < 5) $display("FAIL sweep_done v=%0d latency=%0d unstable=%0d exp=9/0", v, d, u);
      end
      last_bcd = dec_model(v);
    end
    // One trailing Done-free window confirms no extra pulse after the last result.
    @(posedge Clk); #1;
    checks++; if (Done !== 1'b0) begin errors++; bad_hold++; $display("FAIL sweep_extra_done got=%b exp=0", Done); end
  endtask

  task automatic test_random;
    int d, b, u;
    logic [11:0] got;
    logic [8:0] v;
    for (int n = 0; n < 40; n++) begin
      v = 9'($urandom_range(0, 511));
      repeat ($urandom_range(0, 3)) @(posedge Clk);
      #1;
      do_conv(v, last_bcd, d, b, got, u);
      checks++;
      if (got !== dec_model(v) || d !== 9 || b !== 8 || u !== 0) begin
        errors++;
        $display("FAIL rand v=%0d bcd=%h exp=%h lat=%0d busy=%0d unstable=%0d", v, got, dec_model(v), d, b, u);
      end
      last_bcd = dec_model(v);
    end
  endtask

  initial begin
    R = 1'b0; Start = 1'b0; Bin = '0; last_bcd = '0;
    #1;
    test_reset;
    test_directed;
    test_ignore_start;
    test_reset_abort;
    test_back_to_back;
    repeat (2) @(posedge Clk);
    #1;
    test_sweep;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
